fp_add_sub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 style floating-point adder/subtractor for the ALU datapath. It replaces the single-cycle half-precision adder. Exponent and mantissa widths are parameters, and rounding is true round-to-nearest-even with guard, round and sticky bits. A valid/ready handshake lets the ALU issue one operation per cycle and tolerate backpressure.

---
 rtl/fp_add_sub_pipe.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fp_add_sub_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even.
// Define FP_ADD_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fp_add_sub_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   x,
   input  logic [EXP_W+MAN_W:0]   y,
   input  logic                   add_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   r,
   output logic                   negative,
   output logic                   zero,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   inexact,
   output logic                   inf,
   output logic                   nan,
   output logic                   subnormal
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int MW  = MAN_W + 4;
   localparam int LZW = $clog2(MW + 1);
   localparam int CW  = ((LZW > EXP_W) ? LZW : EXP_W) + 1;
   localparam logic [CW-1:0] SH_MAX = CW'(MAN_W + 3);
   localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_ADD_SUBNORMAL_EN
   localparam bit SUBNORM_EN = 1'b1;
`else
   localparam bit SUBNORM_EN = 1'b0;
`endif

   logic advance;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
      logic [LZW-1:0] n;
      logic           hit;
      n   = '0;
      hit = 1'b0;
      for (int i = MW - 1; i >= 0; i--) begin
         if (!hit && !v[i]) n = n + LZW'(1);
         else               hit = 1'b1;
      end
      return n;
   endfunction

   // ---------------- S1: unpack, special detect, order and align
   logic               sx, sy;
   logic [EXP_W-1:0]   ex, ey;
   logic [MAN_W-1:0]   fx, fy;
   logic               x_nan, y_nan, x_inf, y_inf;
   logic               spec_c;
   logic [W-1:0]       spec_val_c;
   logic               x_ge_y;
   logic               sa_c, sb_c;
   logic [EXP_W-1:0]   e_big, e_sml, ea_c, eb_c, dsh;
   logic [MAN_W-1:0]   f_big, f_sml;
   logic [MAN_W:0]     ma_c, mb_c;
   logic [MW-1:0]      a_ext, b_ext, b_sh;

   always_comb begin
      sx = x[W-1];
      sy = y[W-1] ^ add_sub;
      ex = x[W-2:MAN_W];
      ey = y[W-2:MAN_W];
      fx = x[MAN_W-1:0];
      fy = y[MAN_W-1:0];
      x_nan = (&ex) & (|fx);
      y_nan = (&ey) & (|fy);
      x_inf = (&ex) & ~(|fx);
      y_inf = (&ey) & ~(|fy);
      // Without gradual underflow a subnormal operand is read as a signed zero.
      if (!SUBNORM_EN && ex == '0) fx = '0;
      if (!SUBNORM_EN && ey == '0) fy = '0;

      spec_c     = 1'b0;
      spec_val_c = '0;
      if (x_nan | y_nan | (x_inf & y_inf & (sx ^ sy))) begin
         spec_c     = 1'b1;
         spec_val_c = QNAN;
      end else if (x_inf) begin
         spec_c     = 1'b1;
         spec_val_c = {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (y_inf) begin
         spec_c     = 1'b1;
         spec_val_c = {sy, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end

      x_ge_y = {ex, fx} >= {ey, fy};
      if (x_ge_y) begin
         sa_c  = sx;
         sb_c  = sy;
         e_big = ex;
         f_big = fx;
         e_sml = ey;
         f_sml = fy;
      end else begin
         sa_c  = sy;
         sb_c  = sx;
         e_big = ey;
         f_big = fy;
         e_sml = ex;
         f_sml = fx;
      end
      ea_c  = (e_big == '0) ? EXP_W'(1) : e_big;
      eb_c  = (e_sml == '0) ? EXP_W'(1) : e_sml;
      ma_c  = {|e_big, f_big};
      mb_c  = {|e_sml, f_sml};
      dsh   = ea_c - eb_c;
      a_ext = {ma_c, 3'b000};
      b_ext = {mb_c, 3'b000};
      if (CW'(dsh) >= SH_MAX) begin
         b_sh = {{(MW-1){1'b0}}, |mb_c};
      end else begin
         b_sh    = b_ext >> dsh;
         b_sh[0] = b_sh[0] | (|(b_ext & ~({MW{1'b1}} << dsh)));
      end
   end

   logic               s1_valid, s1_spec, s1_sign, s1_sub;
   logic [W-1:0]       s1_spec_val;
   logic [EXP_W-1:0]   s1_exp;
   logic [MW-1:0]      s1_ma, s1_mb;

   // ---------------- S2: add/subtract magnitudes and normalise
   logic [MW:0]        sum_c;
   logic [MW-1:0]      m_pre, m_c;
   logic [LZW-1:0]     lz;
   logic [CW-1:0]      sh_c;
   logic [EXP_W-1:0]   e_c;

   always_comb begin
      sum_c = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
      m_pre = sum_c[MW-1:0];
      lz    = '0;
      sh_c  = '0;
      m_c   = m_pre;
      e_c   = s1_exp;
      if (!s1_sub && sum_c[MW]) begin
         m_c    = sum_c[MW:1];
         m_c[0] = sum_c[1] | sum_c[0];
         e_c    = s1_exp + EXP_W'(1);
      end else begin
         lz = lzc(m_pre);
         // Never shift the exponent below 1; what remains is a subnormal.
         if (CW'(lz) < CW'(s1_exp)) sh_c = CW'(lz);
         else                       sh_c = CW'(s1_exp) - CW'(1);
         m_c = m_pre << sh_c;
         e_c = m_c[MW-1] ? (s1_exp - sh_c[EXP_W-1:0]) : '0;
      end
   end

   logic               s2_valid, s2_spec, s2_sign, s2_sub;
   logic [W-1:0]       s2_spec_val;
   logic [EXP_W-1:0]   s2_exp;
   logic [MW-1:0]      s2_man;

   // ---------------- S3: round, pack, flags
   logic               g_b, r_b, s_b, lsb_b, inc, inex;
   logic [MAN_W+1:0]   mr;
   logic [EXP_W:0]     ef;
   logic [MAN_W-1:0]   ff;
   logic               sgn_c;
   logic [W-1:0]       r_c;
   logic               ovf_c, unf_c, inx_c;
   logic               neg_f, zero_f, inf_f, nan_f, sub_f;

   always_comb begin
      lsb_b = s2_man[3];
      g_b   = s2_man[2];
      r_b   = s2_man[1];
      s_b   = s2_man[0];
      inex  = g_b | r_b | s_b;
      inc   = g_b & (r_b | s_b | lsb_b);
      mr    = {1'b0, s2_man[MW-1:3]} + (MAN_W+2)'(inc);
      ff    = mr[MAN_W-1:0];
      ef    = {1'b0, s2_exp};
      if (mr[MAN_W+1]) begin
         ef = {1'b0, s2_exp} + (EXP_W+1)'(1);
         ff = mr[MAN_W:1];
      end else if (s2_exp == '0 && mr[MAN_W]) begin
         ef = (EXP_W+1)'(1);
      end
      // Exact cancellation of opposite signs gives +0.
      sgn_c = (s2_man == '0 && s2_sub) ? 1'b0 : s2_sign;
      ovf_c = 1'b0;
      unf_c = 1'b0;
      inx_c = inex;
      r_c   = {sgn_c, ef[EXP_W-1:0], ff};
      if (s2_spec) begin
         r_c   = s2_spec_val;
         inx_c = 1'b0;
      end else if (ef >= {1'b0, {EXP_W{1'b1}}}) begin
         r_c   = {sgn_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         ovf_c = 1'b1;
         inx_c = 1'b1;
      end else if (ef == '0) begin
         if (SUBNORM_EN) begin
            unf_c = inex;
         end else if (s2_man != '0) begin
            r_c   = {sgn_c, {(W-1){1'b0}}};
            unf_c = 1'b1;
            inx_c = 1'b1;
         end
      end
      neg_f  = r_c[W-1];
      zero_f = (r_c[W-2:0] == '0);
      inf_f  = (&r_c[W-2:MAN_W]) & ~(|r_c[MAN_W-1:0]);
      nan_f  = (&r_c[W-2:MAN_W]) & (|r_c[MAN_W-1:0]);
      sub_f  = (r_c[W-2:MAN_W] == '0) & (|r_c[MAN_W-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_spec     <= 1'b0;
         s1_spec_val <= '0;
         s1_sign     <= 1'b0;
         s1_sub      <= 1'b0;
         s1_exp      <= '0;
         s1_ma       <= '0;
         s1_mb       <= '0;
         s2_valid    <= 1'b0;
         s2_spec     <= 1'b0;
         s2_spec_val <= '0;
         s2_sign     <= 1'b0;
         s2_sub      <= 1'b0;
         s2_exp      <= '0;
         s2_man      <= '0;
         out_valid   <= 1'b0;
         r           <= '0;
         negative    <= 1'b0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         inexact     <= 1'b0;
         inf         <= 1'b0;
         nan         <= 1'b0;
         subnormal   <= 1'b0;
      end else if (advance) begin
         s1_valid    <= in_valid;
         s1_spec     <= spec_c;
         s1_spec_val <= spec_val_c;
         s1_sign     <= sa_c;
         s1_sub      <= sa_c ^ sb_c;
         s1_exp      <= ea_c;
         s1_ma       <= a_ext;
         s1_mb       <= b_sh;
         s2_valid    <= s1_valid;
         s2_spec     <= s1_spec;
         s2_spec_val <= s1_spec_val;
         s2_sign     <= s1_sign;
         s2_sub      <= s1_sub;
         s2_exp      <= e_c;
         s2_man      <= m_c;
         out_valid   <= s2_valid;
         if (s2_valid) begin
            r         <= r_c;
            negative  <= neg_f;
            zero      <= zero_f;
            overflow  <= ovf_c;
            underflow <= unf_c;
            inexact   <= inx_c;
            inf       <= inf_f;
            nan       <= nan_f;
            subnormal <= sub_f;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Scoreboard bench for fp_add_sub_pipe at default half-precision parameters.
module tb_fp_add_sub_pipe;
   localparam int NV = 18;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, add_sub, out_valid, out_ready;
   logic [15:0] x, y, r;
   logic        negative, zero, overflow, underflow, inexact, inf, nan, subnormal;
   logic [7:0]  flags;

   assign flags = {negative, zero, overflow, underflow, inexact, inf, nan, subnormal};

   always #5 clk = ~clk;

   fp_add_sub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .add_sub(add_sub), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .negative(negative), .zero(zero), .overflow(overflow), .underflow(underflow),
      .inexact(inexact), .inf(inf), .nan(nan), .subnormal(subnormal)
   );

   logic [23:0] sb[$];
   logic [23:0] cur_exp;
   int nvec = 0;
   int nerr = 0;

   logic        t_got, t_empty, t_ov, t_or, t_ir, t_acc;
   logic [23:0] t_obs, t_exp;

   // Flag byte: neg zero ovf unf inx inf nan sub
   task automatic load_vec(input int i);
      logic [15:0] a, b, e;
      logic        op;
      logic [7:0]  f;
      case (i)
         0:  begin a = 16'h3C00; b = 16'h3C00; op = 1'b0; e = 16'h4000; f = 8'h00; end
         1:  begin a = 16'h3C00; b = 16'h3C00; op = 1'b1; e = 16'h0000; f = 8'h40; end
         2:  begin a = 16'h8000; b = 16'h8000; op = 1'b0; e = 16'h8000; f = 8'hC0; end
         3:  begin a = 16'h3C00; b = 16'h1000; op = 1'b0; e = 16'h3C00; f = 8'h08; end
         4:  begin a = 16'h3C01; b = 16'h1000; op = 1'b0; e = 16'h3C02; f = 8'h08; end
         5:  begin a = 16'h7BFF; b = 16'h7BFF; op = 1'b0; e = 16'h7C00; f = 8'h2C; end
         6:  begin a = 16'h7C00; b = 16'h7C00; op = 1'b1; e = 16'h7E00; f = 8'h02; end
         7:  begin a = 16'hFC00; b = 16'h3C00; op = 1'b0; e = 16'hFC00; f = 8'h84; end
`ifdef FP_ADD_SUBNORMAL_EN
         8:  begin a = 16'h0001; b = 16'h0001; op = 1'b0; e = 16'h0002; f = 8'h01; end
`else
         8:  begin a = 16'h0001; b = 16'h0001; op = 1'b0; e = 16'h0000; f = 8'h40; end
`endif
         9:  begin a = 16'h4000; b = 16'h3C00; op = 1'b0; e = 16'h4200; f = 8'h00; end
         10: begin a = 16'h3C00; b = 16'h4000; op = 1'b1; e = 16'hBC00; f = 8'h80; end
         11: begin a = 16'hC000; b = 16'hC000; op = 1'b0; e = 16'hC400; f = 8'h80; end
         12: begin a = 16'h3C00; b = 16'h1000; op = 1'b1; e = 16'h3BFF; f = 8'h00; end
         13: begin a = 16'h3C00; b = 16'h1001; op = 1'b0; e = 16'h3C01; f = 8'h08; end
         14: begin a = 16'h3C00; b = 16'hFC00; op = 1'b1; e = 16'h7C00; f = 8'h04; end
         15: begin a = 16'h7E01; b = 16'h3C00; op = 1'b0; e = 16'h7E00; f = 8'h02; end
         16: begin a = 16'h0000; b = 16'h0000; op = 1'b1; e = 16'h0000; f = 8'h40; end
`ifdef FP_ADD_SUBNORMAL_EN
         default: begin a = 16'h0800; b = 16'h0600; op = 1'b1; e = 16'h0200; f = 8'h01; end
`else
         default: begin a = 16'h0800; b = 16'h0600; op = 1'b1; e = 16'h0000; f = 8'h58; end
`endif
      endcase
      x = a;
      y = b;
      add_sub = op;
      cur_exp = {e, f};
   endtask

   // One clock: observe handshakes at the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      t_ov    = out_valid;
      t_or    = out_ready;
      t_ir    = in_ready;
      t_got   = out_valid & out_ready;
      t_acc   = in_valid & in_ready;
      t_obs   = {r, flags};
      t_empty = 1'b0;
      t_exp   = '0;
      if (t_got) begin
         if (sb.size() == 0) t_empty = 1'b1;
         else                t_exp = sb.pop_front();
      end
      if (t_acc) sb.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; add_sub = 1'b0; out_ready = 1'b0;
      cur_exp = '0;
      #12;
      nvec++;
      if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      nvec++;
      if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      nvec++;
      if ({r, flags} !== 24'h0) begin nerr++; $display("FAIL reset_outputs got %h want 000000", {r, flags}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      int lat;
      bit done;
      out_ready = 1'b1;
      load_vec(0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         tick();
         if (t_got) begin
            done = 1'b1;
            nvec++;
            if (lat != 3) begin nerr++; $display("FAIL latency got %0d want 3", lat); end
            nvec++;
            if (t_empty || t_obs !== t_exp)
               begin nerr++; $display("FAIL latency_result got %h want %h", t_obs, t_exp); end
         end else begin
            lat++;
         end
      end
      if (!done) begin nerr++; $display("FAIL latency_timeout no out_valid within 10 cycles"); end
   endtask

   task automatic test_back_to_back();
      int sent, recv, ticks;
      sent = 0; recv = 0; ticks = 0;
      out_ready = 1'b1;
      while (recv < NV && ticks < 200) begin
         if (sent < NV) begin load_vec(sent); in_valid = 1'b1; end
         else in_valid = 1'b0;
         tick();
         ticks++;
         if (t_acc) sent++;
         if (t_got) begin
            nvec++;
            if (t_empty || t_obs !== t_exp)
               begin nerr++; $display("FAIL vector_%0d got %h want %h", recv, t_obs, t_exp); end
            recv++;
         end
      end
      in_valid = 1'b0;
      nvec++;
      if (recv != NV || ticks != NV + 3)
         begin nerr++; $display("FAIL throughput got %0d results in %0d cycles want %0d in %0d", recv, ticks, NV, NV + 3); end
   endtask

   int bp_ids[6] = '{0, 3, 4, 5, 9, 10};

   task automatic test_backpressure();
      int sent, recv, t;
      bit held_vld;
      logic [23:0] held;
      sent = 0; recv = 0; t = 0; held_vld = 1'b0; held = '0;
      while (recv < 6 && t < 300) begin
         out_ready = (t % 3 == 0);
         if (sent < 6) begin load_vec(bp_ids[sent]); in_valid = 1'b1; end
         else in_valid = 1'b0;
         tick();
         t++;
         if (t_acc) sent++;
         if (held_vld) begin
            nvec++;
            if (!t_ov || t_obs !== held)
               begin nerr++; $display("FAIL stall_hold got vld=%b %h want vld=1 %h", t_ov, t_obs, held); end
         end
         if (t_ov && !t_or) begin
            nvec++;
            if (t_ir !== 1'b0) begin nerr++; $display("FAIL stall_in_ready got %b want 0", t_ir); end
         end
         held_vld = t_ov & ~t_or;
         held = t_obs;
         if (t_got) begin
            nvec++;
            if (t_empty || t_obs !== t_exp)
               begin nerr++; $display("FAIL bp_result_%0d got %h want %h", recv, t_obs, t_exp); end
            recv++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (t_got) begin
            nvec++; nerr++;
            $display("FAIL bp_extra got unexpected result %h", t_obs);
         end
      end
      nvec++;
      if (recv != 6 || sb.size() != 0)
         begin nerr++; $display("FAIL bp_count got %0d results, %0d pending want 6, 0", recv, sb.size()); end
   endtask

   task automatic test_reset_midflight();
      bit done;
      out_ready = 1'b1;
      load_vec(0);  in_valid = 1'b1; tick();
      load_vec(9);  in_valid = 1'b1; tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      nvec++;
      if (out_valid !== 1'b0) begin nerr++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         nvec++;
         if (t_ov !== 1'b0) begin nerr++; $display("FAIL stale_out_valid cycle %0d got %b want 0", k, t_ov); end
      end
      load_vec(13); in_valid = 1'b1; tick();
      in_valid = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         tick();
         if (t_got) begin
            done = 1'b1;
            nvec++;
            if (t_empty || t_obs !== t_exp)
               begin nerr++; $display("FAIL post_reset_result got %h want %h", t_obs, t_exp); end
         end
      end
      if (!done) begin nerr++; $display("FAIL post_reset_timeout no result within 10 cycles"); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
